// File: rtl/mem_req_arbiter_if.sv
// Bundle of the upstream fetch/data request ports and the downstream
// sram-like memory port that mem_req_arbiter sits between.
//   slave  : arbiter view (takes requests, drives the memory port)
//   master : environment view (requesters plus downstream memory)
interface mem_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Instruction-fetch requester (read-only)
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Data-memory requester (read/write)
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [STRB_W-1:0] data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Shared downstream memory port
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata, mem_wstrb,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata, mem_wstrb,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between instruction fetch (read-only)
// and data memory (read/write). One transaction in flight at a time; data
// wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
// Flushed fetches complete downstream but their response never reaches IF.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus_io : request/response bundle (slave modport), see mem_req_arbiter_if
module mem_req_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_req_arbiter_if.slave  bus_io
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = inst, 1 = data
  logic              drop_q,  drop_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              wr_q,    wr_d;
  logic [1:0]        size_q,  size_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rst_q;

  logic hold;
  logic grant_inst, grant_data;
  logic inst_addr_ok_c, data_addr_ok_c;
  logic inst_data_ok_c, data_data_ok_c;
  logic mem_req_c;

  // Outputs stay quiet in the reset cycle and the one after it
  assign hold = reset | rst_q;

  // State register
  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next-state and combinational handshake outputs
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    drop_d         = drop_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    grant_inst     = 1'b0;
    grant_data     = 1'b0;
    inst_addr_ok_c = 1'b0;
    data_addr_ok_c = 1'b0;
    inst_data_ok_c = 1'b0;
    data_data_ok_c = 1'b0;
    mem_req_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!hold) begin
          grant_inst = bus_io.inst_req & (~bus_io.data_req | (cnt_q == LIMIT));
          grant_data = bus_io.data_req & ~grant_inst;
        end
        if (grant_inst) begin
          inst_addr_ok_c = 1'b1;
          owner_d        = 1'b0;
          wr_d           = 1'b0;
          size_d         = 2'd2;
          addr_d         = bus_io.inst_addr;
          wdata_d        = '0;
          wstrb_d        = '0;
          drop_d         = bus_io.inst_cancel;
          cnt_d          = '0;
          state_d        = ADDR;
        end else if (grant_data) begin
          data_addr_ok_c = 1'b1;
          owner_d        = 1'b1;
          wr_d           = bus_io.data_wr;
          size_d         = bus_io.data_size;
          addr_d         = bus_io.data_addr;
          wdata_d        = bus_io.data_wdata;
          wstrb_d        = bus_io.data_wstrb;
          drop_d         = 1'b0;
          // Count only grants that made a waiting fetch lose
          if (!bus_io.inst_req)   cnt_d = '0;
          else if (cnt_q < LIMIT) cnt_d = CNT_W'(cnt_q + CNT_W'(1));
          state_d        = ADDR;
        end
      end

      ADDR: begin
        mem_req_c = 1'b1;
        if (!owner_q && bus_io.inst_cancel) drop_d = 1'b1;
        if (bus_io.mem_addr_ok) state_d = DATA;
      end

      DATA: begin
        if (bus_io.mem_data_ok) begin
          // A cancel coincident with the response also suppresses it
          data_data_ok_c = owner_q;
          inst_data_ok_c = ~owner_q & ~drop_q & ~bus_io.inst_cancel;
          drop_d         = 1'b0;
          state_d        = IDLE;
        end else if (!owner_q && bus_io.inst_cancel) begin
          drop_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus_io.inst_addr_ok = inst_addr_ok_c & ~hold;
  assign bus_io.data_addr_ok = data_addr_ok_c & ~hold;
  assign bus_io.inst_data_ok = inst_data_ok_c & ~hold;
  assign bus_io.data_data_ok = data_data_ok_c & ~hold;
  assign bus_io.inst_rdata   = hold ? '0 : bus_io.mem_rdata;
  assign bus_io.data_rdata   = hold ? '0 : bus_io.mem_rdata;

  assign bus_io.mem_req   = mem_req_c & ~hold;
  assign bus_io.mem_wr    = wr_q & ~hold;
  assign bus_io.mem_size  = hold ? '0 : size_q;
  assign bus_io.mem_addr  = hold ? '0 : addr_q;
  assign bus_io.mem_wdata = hold ? '0 : wdata_q;
  assign bus_io.mem_wstrb = hold ? '0 : wstrb_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter. A transaction-level timeline model
// decides grants and response timing; expected grants, downstream requests
// and upstream responses are queued and popped by an independent monitor.
module tb_mem_req_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int          LIMIT  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } rsp_t;

  bit   grant_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Model / driver state
  int   cyc       = 0;
  bit   blk       = 1'b1;
  int   allow_cyc = 0;
  int   done_cyc  = -1;
  int   addr_cyc  = -1;
  int   data_cyc  = -1;
  bit   cur_data;
  bit   cur_drop;
  logic [31:0] cur_rdata;
  int   starve    = 0;

  bit          ip = 1'b0;
  logic [31:0] ia = '0;
  bit          dp = 1'b0;
  req_t        dr;

  int p_inst = 0, p_data = 0, p_cancel = 0, p_stray = 0, p_reset = 0;
  int a_lo = 1, a_hi = 1, d_lo = 1, d_hi = 1;
  bit          force_rdata = 1'b0;
  logic [31:0] forced_rdata = '0;

  function automatic bit roll(int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // One clock cycle: drive inputs, then advance the reference timeline
  task automatic step(input bit rst_in);
    bit   cancel, busy, in_addr, in_data, ao, dok, gi, gd, rst;
    logic [31:0] rd;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_in | roll(p_reset);

    if (!ip && roll(p_inst)) begin
      ip = 1'b1;
      ia = $urandom & 32'hFFFF_FFFC;
    end
    if (!dp && roll(p_data)) begin
      dp       = 1'b1;
      dr.wr    = 1'($urandom_range(1));
      dr.size  = 2'($urandom_range(2));
      dr.addr  = $urandom;
      dr.wdata = $urandom;
      dr.wstrb = 4'($urandom_range(15));
    end
    cancel = roll(p_cancel);

    if (rst) begin
      grant_q.delete();
      req_q.delete();
      rsp_q.delete();
      done_cyc  = -1;
      starve    = 0;
      allow_cyc = cyc + 2;
    end
    busy    = (cyc <= done_cyc);
    in_addr = busy && (cyc <= addr_cyc);
    in_data = busy && (cyc > addr_cyc);
    blk     = rst || (cyc < allow_cyc);

    if (busy && !cur_data && cancel) cur_drop = 1'b1;
    ao  = (busy && cyc == addr_cyc) || (!in_addr && roll(p_stray));
    dok = (busy && cyc == data_cyc) || (!in_data && roll(p_stray));
    rd  = (busy && cyc == data_cyc) ? cur_rdata : $urandom;
    if (busy && cyc == data_cyc) begin
      if (cur_data)       rsp_q.push_back('{1'b1, cur_rdata});
      else if (!cur_drop) rsp_q.push_back('{1'b0, cur_rdata});
    end

    reset            = rst;
    bus.inst_req     = ip;
    bus.inst_addr    = ia;
    bus.inst_cancel  = cancel;
    bus.data_req     = dp;
    bus.data_wr      = dr.wr;
    bus.data_size    = dr.size;
    bus.data_addr    = dr.addr;
    bus.data_wdata   = dr.wdata;
    bus.data_wstrb   = dr.wstrb;
    bus.mem_addr_ok  = ao;
    bus.mem_data_ok  = dok;
    bus.mem_rdata    = rd;

    gi = 1'b0;
    gd = 1'b0;
    if (!rst && !busy && cyc >= allow_cyc) begin
      gi = ip && (!dp || starve == LIMIT);
      gd = dp && !gi;
    end
    if (gi) begin
      grant_q.push_back(1'b0);
      r = '{1'b0, 2'd2, ia, 32'h0, 4'h0};
      req_q.push_back(r);
      starve   = 0;
      cur_data = 1'b0;
      cur_drop = cancel;
      ip       = 1'b0;
    end else if (gd) begin
      grant_q.push_back(1'b1);
      req_q.push_back(dr);
      starve   = ip ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      cur_data = 1'b1;
      cur_drop = 1'b0;
      dp       = 1'b0;
    end
    if (gi || gd) begin
      addr_cyc  = cyc + int'($urandom_range(a_hi, a_lo));
      data_cyc  = addr_cyc + int'($urandom_range(d_hi, d_lo));
      done_cyc  = data_cyc;
      cur_rdata = force_rdata ? forced_rdata : $urandom;
      force_rdata = 1'b0;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (blk) begin
      chk("reset_quiet",
          128'(|{bus.inst_addr_ok, bus.inst_data_ok, bus.inst_rdata,
                 bus.data_addr_ok, bus.data_data_ok, bus.data_rdata,
                 bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr,
                 bus.mem_wdata, bus.mem_wstrb}), 128'd0);
    end else begin
      if (bus.inst_addr_ok || bus.data_addr_ok) begin
        if (grant_q.size() == 0) chk("grant_unexpected", 128'd1, 128'd0);
        else begin
          bit g;
          g = grant_q.pop_front();
          chk("grant_who", 128'({bus.inst_addr_ok, bus.data_addr_ok}),
              g ? 128'd1 : 128'd2);
        end
      end
      if (bus.mem_req && bus.mem_addr_ok) begin
        if (req_q.size() == 0) chk("mem_req_unexpected", 128'd1, 128'd0);
        else begin
          req_t e;
          e = req_q.pop_front();
          chk("mem_fields",
              128'({bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}),
              128'({e.wr, e.size, e.addr, e.wdata, e.wstrb}));
        end
      end
      if (bus.inst_data_ok || bus.data_data_ok) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 128'd1, 128'd0);
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_who", 128'({bus.inst_data_ok, bus.data_data_ok}),
              e.is_data ? 128'd1 : 128'd2);
          chk("rsp_rdata", 128'(e.is_data ? bus.data_rdata : bus.inst_rdata),
              128'(e.rdata));
        end
      end
    end
  end

  initial begin
    dr = '{1'b0, 2'd0, 32'h0, 32'h0, 4'h0};
    reset = 1'b1;
    step(1'b1);
    step(1'b1);

    // Single fetch: grant, accept next cycle, respond two cycles later
    ip = 1'b1;
    ia = 32'hBFC0_0000;
    a_lo = 1; a_hi = 1; d_lo = 2; d_hi = 2;
    force_rdata  = 1'b1;
    forced_rdata = 32'h2408_0001;
    repeat (6) step(1'b0);

    // Simultaneous fetch and store: store goes first
    ip = 1'b1;
    ia = 32'h0000_0100;
    dp = 1'b1;
    dr = '{1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF};
    a_lo = 1; a_hi = 1; d_lo = 1; d_hi = 1;
    repeat (10) step(1'b0);

    // Both requesters saturated: fetch wins every fifth grant
    p_inst = 100; p_data = 100;
    repeat (40) step(1'b0);

    // Reset while a fetch waits in DATA, then stray responses
    p_inst = 0; p_data = 0;
    repeat (8) step(1'b0);
    ip = 1'b1;
    ia = 32'h0000_0400;
    d_lo = 5; d_hi = 5;
    repeat (3) step(1'b0);
    step(1'b1);
    p_stray = 60;
    repeat (8) step(1'b0);

    // Random traffic with cancels, stray handshakes and occasional resets
    p_inst = 40; p_data = 40; p_cancel = 15; p_stray = 10; p_reset = 0;
    a_lo = 1; a_hi = 3; d_lo = 1; d_hi = 4;
    repeat (1500) step(1'b0);
    p_reset = 1;
    repeat (1500) step(1'b0);

    // Drain
    p_inst = 0; p_data = 0; p_cancel = 0; p_stray = 0; p_reset = 0;
    repeat (40) step(1'b0);
    @(posedge clk);
    #1;
    chk("grant_q_empty", 128'(grant_q.size()), 128'd0);
    chk("req_q_empty",   128'(req_q.size()),   128'd0);
    chk("rsp_q_empty",   128'(rsp_q.size()),   128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Sits between the IF/MEM stages and the AXI bridge.
- Keeps exactly one transaction in flight. Data requests have priority, bounded by an anti-starvation counter for fetch.
- Supports fetch cancellation on exception/flush, so responses from flushed fetches never reach IF.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch waits; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  flush pulse from exception logic
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_wstrb  in  DATA_W/8  byte enables
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data or store completion
- data_rdata  out  DATA_W  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_wstrb  out  DATA_W/8  downstream strobes
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- State machine states: IDLE, ADDR, DATA.
- Registered state:
  - owner (0 = inst, 1 = data).
  - Latched request fields: wr, size, addr, wdata, wstrb.
  - drop flag.
  - starve counter, 4 bits.
- Reset:
  - state = IDLE, owner = 0, drop = 0, counter = 0, all latched fields = 0.
  - Every output is 0 during the reset cycle and the cycle after, regardless of inputs.
  - A transaction already in flight is abandoned; the downstream side is reset together with this block.
- IDLE:
  - Grant selection:
    - Only inst_req: inst wins.
    - Only data_req: data wins.
    - Both, with counter == STARVE_LIMIT: inst wins.
    - Both otherwise: data wins.
  - The winner's addr_ok is combinationally 1 in the same cycle. The loser's addr_ok is 0.
  - On grant: latch fields and owner, then go to ADDR.
  - Inst grants latch wr = 0, size = 2, wstrb = 0.
- Starve counter updates on each grant:
  - Data grant while inst_req = 1: counter +1, saturating at STARVE_LIMIT.
  - Inst grant: counter cleared.
  - Data grant while inst_req = 0: counter cleared.
- ADDR:
  - mem_req = 1; mem_wr, mem_size, mem_addr, mem_wdata, mem_wstrb come from the latched fields.
  - On mem_addr_ok, go to DATA.
  - Fields stay stable until then.
  - Upstream addr_ok stays 0.
- DATA:
  - mem_req = 0.
  - On mem_data_ok:
    - Forward the response combinationally, in the same cycle, to the owner: owner_data_ok = 1, owner_rdata = mem_rdata.
    - Return to IDLE.
    - A new grant can occur in the following cycle, not the same one.
  - rdata outputs are don't-care when the matching data_ok = 0; they are driven as mem_rdata.
- Fetch cancellation:
  - inst_cancel = 1 while owner = inst in ADDR or DATA sets drop.
  - inst_cancel = 1 in the IDLE cycle that grants inst also sets drop.
  - When mem_data_ok arrives with drop = 1, or with inst_cancel = 1 in the same cycle, inst_data_ok is suppressed; drop clears on leaving DATA.
  - inst_cancel has no effect while data owns the port or when idle with no fetch granted.
  - Data transactions are never cancelled.
- mem_addr_ok in IDLE or DATA, and mem_data_ok in IDLE or ADDR, are protocol violations; they are ignored.
- Latency:
  - Grant at cycle 0.
  - mem_req rises at cycle 1.
  - Minimum response at cycle 2, when mem_addr_ok comes at cycle 1 and mem_data_ok at cycle 2.
  - Minimum back-to-back issue: one transaction per 3 cycles.

Test Plan:
- Inst only, addr 0xBFC00000; mem_addr_ok at cycle 1, mem_data_ok at cycle 3 with rdata 0x24080001 -> inst_addr_ok at cycle 0; mem_req = 1 at cycles 1; inst_data_ok = 1 with rdata 0x24080001 at cycle 3 only.
- Both request at cycle 0 (inst 0x100, data store 0x200, wdata 0xDEADBEEF, wstrb 0xF) -> data granted first with mem_wr = 1, mem_wstrb = 0xF; inst granted on the next IDLE.
- STARVE_LIMIT = 4; inst_req and data_req held continuously -> grant order data, data, data, data, inst; counter reads 0 after the inst grant.
- Inst granted; inst_cancel pulse in DATA state before mem_data_ok -> inst_data_ok stays 0 for that response; the next fetch completes normally.
- inst_cancel coincident with mem_data_ok -> inst_data_ok = 0; inst_cancel while data owns the port -> data_data_ok delivered.
- reset asserted in DATA state -> next cycle state IDLE, mem_req = 0, all ok outputs 0; a stray mem_data_ok afterwards is ignored.
